// File: rtl/rns_987_pkg.sv
// Shared constants and FSM encoding for the {9,8,7} residue number system.
// Used by the binary-to-RNS converter and its mod-step datapath.
package rns_987_pkg;

    localparam int M1    = 9;
    localparam int M2    = 8;
    localparam int M3    = 7;
    localparam int RANGE = 504;

    localparam int W1 = 4;
    localparam int W2 = 3;
    localparam int W3 = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/rns_mod_step.sv
// One MSB-first Horner step: r_o = (2*r_i + b_i) mod M.
// Inputs are assumed reduced (r_i < M), so one conditional subtract suffices.
module rns_mod_step #(
    parameter int M = 9,
    parameter int W = 4
) (
    input  logic [W-1:0] r_i,
    input  logic         b_i,
    output logic [W-1:0] r_o
);

    logic [W:0] t;

    assign t   = {r_i, b_i};
    assign r_o = (t >= (W+1)'(M)) ? W'(t - (W+1)'(M)) : W'(t);

endmodule

// File: rtl/bin_to_rns_987_seq.sv
// Bit-serial binary to {9,8,7} residue converter, one bit per clock.
// Optional x >= 504 flag enabled by BIN_TO_RNS_RANGE_CHECK_EN.
module bin_to_rns_987_seq
    import rns_987_pkg::*;
#(
    parameter int IN_WIDTH = 9
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [IN_WIDTH-1:0] x_in,
    input  logic                valid_in,
    output logic                ready_out,
    output logic [W1-1:0]       a1_out,
    output logic [W2-1:0]       a2_out,
    output logic [W3-1:0]       a3_out,
    output logic                valid_out,
    input  logic                ready_in
`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    ,
    output logic                range_err_out
`endif
);

    localparam int CW = $clog2(IN_WIDTH);

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] sh_q;
    logic [CW-1:0]       cnt_q;
    logic [W1-1:0]       r9_q, r9_d;
    logic [W2-1:0]       r8_q;
    logic [W3-1:0]       r7_q, r7_d;
    logic                b;
    logic                last;
    logic                accept;

    assign b      = sh_q[IN_WIDTH-1];
    assign last   = (cnt_q == CW'(IN_WIDTH - 1));
    assign accept = valid_in && ready_out;

    rns_mod_step #(.M(M1), .W(W1)) u_step9 (
        .r_i (r9_q),
        .b_i (b),
        .r_o (r9_d)
    );

    rns_mod_step #(.M(M3), .W(W3)) u_step7 (
        .r_i (r7_q),
        .b_i (b),
        .r_o (r7_d)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (valid_in) state_d = CONV;
            CONV:    if (last)     state_d = HOLD;
            HOLD:    if (ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready_out = (state_q == IDLE);
        valid_out = (state_q == HOLD);
    end

    // Working registers double as the output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sh_q  <= '0;
            cnt_q <= '0;
            r9_q  <= '0;
            r8_q  <= '0;
            r7_q  <= '0;
        end else if (accept) begin
            sh_q  <= x_in;
            cnt_q <= '0;
            r9_q  <= '0;
            r8_q  <= '0;
            r7_q  <= '0;
        end else if (state_q == CONV) begin
            sh_q  <= {sh_q[IN_WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + CW'(1);
            r9_q  <= r9_d;
            r8_q  <= {r8_q[W2-2:0], b};
            r7_q  <= r7_d;
        end
    end

`ifdef BIN_TO_RNS_RANGE_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_q <= 1'b0;
        end else if (accept) begin
            err_q <= (32'(x_in) >= RANGE);
        end
    end

    assign range_err_out = err_q;
`endif

    assign a1_out = r9_q;
    assign a2_out = r8_q;
    assign a3_out = r7_q;

endmodule
